// File: rtl/seq_addsub.sv
// ---------------------------------------------------------------------------
// seq_addsub
//   Multi-cycle two's-complement adder/subtractor. A WIDTH-bit operation is
//   processed CHUNK bits per clock, least significant chunk first. The carry
//   between chunks is held in a register. Subtraction is x + ~y + 1: the
//   inverted y is captured at start and the initial carry is set to 1.
//
// Ports
//   clk    in   clock, rising edge
//   rst_n  in   synchronous active-low reset
//   start  in   request a new operation (ignored while busy)
//   x, y   in   operands, WIDTH bits, captured on the accepting edge
//   as     in   0 = x+y, 1 = x-y
//   busy   out  operation in progress
//   done   out  one-cycle pulse when s and the flags update
//   s      out  result, held between operations
//   cout   out  carry out of the MSB (subtract: 1 = no borrow)
//   ovf    out  signed overflow
//   zero   out  s == 0
// ---------------------------------------------------------------------------
module seq_addsub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             as,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int N  = WIDTH / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int OW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] opa_r;
    logic [WIDTH-1:0] opb_r;
    logic [WIDTH-1:0] acc_r;
    logic             carry_r;
    logic [IW-1:0]    idx_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] s_r;
    logic             cout_r;
    logic             ovf_r;
    logic             zero_r;

    logic [OW-1:0]    off_s;
    logic [CHUNK-1:0] a_s;
    logic [CHUNK-1:0] b_s;
    logic [CHUNK:0]   sum_s;
    logic             cin_msb_s;
    logic [WIDTH-1:0] acc_next_s;
    logic             last_s;

    // Chunk datapath: add the current slice and merge it into the accumulator.
    always_comb begin
        off_s      = OW'(idx_r) * OW'(CHUNK);
        a_s        = opa_r[off_s +: CHUNK];
        b_s        = opb_r[off_s +: CHUNK];
        sum_s      = {1'b0, a_s} + {1'b0, b_s} + {{CHUNK{1'b0}}, carry_r};
        // A sum bit is a ^ b ^ carry-in, so the carry into the top bit of the
        // slice can be recovered from the sum without a second adder.
        cin_msb_s  = a_s[CHUNK-1] ^ b_s[CHUNK-1] ^ sum_s[CHUNK-1];
        acc_next_s = acc_r;
        acc_next_s[off_s +: CHUNK] = sum_s[CHUNK-1:0];
        last_s     = (idx_r == LAST_IDX);
    end

    // Control FSM, operand capture, chunk sequencing and registered results.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            opa_r   <= {WIDTH{1'b0}};
            opb_r   <= {WIDTH{1'b0}};
            acc_r   <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            idx_r   <= {IW{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            s_r     <= {WIDTH{1'b0}};
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
            zero_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        opa_r   <= x;
                        opb_r   <= y ^ {WIDTH{as}};
                        carry_r <= as;
                        idx_r   <= {IW{1'b0}};
                        busy_r  <= 1'b1;
                        state_r <= RUN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    acc_r   <= acc_next_s;
                    carry_r <= sum_s[CHUNK];
                    if (last_s) begin
                        s_r     <= acc_next_s;
                        cout_r  <= sum_s[CHUNK];
                        ovf_r   <= cin_msb_s ^ sum_s[CHUNK];
                        zero_r  <= (acc_next_s == {WIDTH{1'b0}});
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        idx_r   <= {IW{1'b0}};
                        state_r <= IDLE;
                    end else begin
                        idx_r   <= idx_r + IW'(1'b1);
                        state_r <= RUN;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign s    = s_r;
    assign cout = cout_r;
    assign ovf  = ovf_r;
    assign zero = zero_r;

endmodule

// File: tb/tb_seq_addsub.sv
// ---------------------------------------------------------------------------
// tb_seq_addsub
//   Directed and randomised checks of seq_addsub. u0 uses the default
//   16/4 configuration; u1 (CHUNK=16, one chunk per op) and u2 (CHUNK=1,
//   sixteen chunks per op) share the operand inputs and are run side by
//   side against a reference model.
// ---------------------------------------------------------------------------
module tb_seq_addsub;

    logic        clk;
    logic        rst_n;
    logic [15:0] x;
    logic [15:0] y;
    logic        as;
    logic        start0, start1, start2;
    logic        busy0, busy1, busy2;
    logic        done0, done1, done2;
    logic [15:0] s0, s1, s2;
    logic        cout0, cout1, cout2;
    logic        ovf0, ovf1, ovf2;
    logic        zero0, zero1, zero2;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    seq_addsub #(.WIDTH(16), .CHUNK(4)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .x(x), .y(y), .as(as),
        .busy(busy0), .done(done0), .s(s0), .cout(cout0), .ovf(ovf0), .zero(zero0)
    );

    seq_addsub #(.WIDTH(16), .CHUNK(16)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .x(x), .y(y), .as(as),
        .busy(busy1), .done(done1), .s(s1), .cout(cout1), .ovf(ovf1), .zero(zero1)
    );

    seq_addsub #(.WIDTH(16), .CHUNK(1)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .x(x), .y(y), .as(as),
        .busy(busy2), .done(done2), .s(s2), .cout(cout2), .ovf(ovf2), .zero(zero2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Returns {zero, ovf, cout, s} from plain integer arithmetic and sign rules.
    function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b, input logic m);
        logic [16:0] wide;
        logic [15:0] r;
        logic        c;
        logic        o;
        if (m) begin
            r = a - b;
            c = (a >= b);
            o = (a[15] != b[15]) && (r[15] != a[15]);
        end else begin
            wide = {1'b0, a} + {1'b0, b};
            r    = wide[15:0];
            c    = wide[16];
            o    = (a[15] == b[15]) && (r[15] != a[15]);
        end
        return {(r == 16'h0000), o, c, r};
    endfunction

    // Waits for done0; lat = edges after the start edge, bc = busy cycles.
    task automatic wait_done0(output int lat, output int bc);
        lat = -1;
        bc  = busy0 ? 1 : 0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (busy0) bc++;
            if (done0) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic op0(input string tag, input logic [15:0] a, input logic [15:0] b, input logic m,
                       input logic [15:0] es, input logic ec, input logic eo, input logic ez);
        int lat;
        int bc;
        x = a; y = b; as = m; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        wait_done0(lat, bc);
        check({tag, ".lat"},  lat, 4);
        check({tag, ".busy"}, bc, 4);
        check({tag, ".s"},    s0, es);
        check({tag, ".cout"}, cout0, ec);
        check({tag, ".ovf"},  ovf0, eo);
        check({tag, ".zero"}, zero0, ez);
    endtask

    initial begin
        int lat;
        int bc;
        int dseen;
        int lat1;
        int lat2;
        logic [18:0] exp;

        rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        x = 16'h0000; y = 16'h0000; as = 1'b0;
        tick(); tick();
        check("rst.busy", busy0, 1'b0);
        check("rst.done", done0, 1'b0);
        check("rst.s",    s0, 16'h0000);
        check("rst.flags", {cout0, ovf0, zero0}, 3'b000);
        rst_n = 1'b1;
        tick();

        // Basic add and subtract cases, including borrow, zero and overflow.
        op0("add2p4",   16'h0002, 16'h0004, 1'b0, 16'h0006, 1'b0, 1'b0, 1'b0);
        op0("subFFFF",  16'hFFFF, 16'hFFFC, 1'b1, 16'h0003, 1'b1, 1'b0, 1'b0);
        op0("sub3m5",   16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        op0("sub5m5",   16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        op0("add7FFF",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        op0("addFFFF",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        op0("sub8000",  16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);

        // start held high and operands changed during RUN: only the captured op counts.
        x = 16'h0100; y = 16'h0023; as = 1'b0; start0 = 1'b1;
        tick();
        x = 16'hAAAA; y = 16'h5555; as = 1'b1; tick();
        x = 16'h1111; y = 16'h9999; as = 1'b0; tick();
        x = 16'hFFFF; y = 16'h0001; as = 1'b1; tick();
        start0 = 1'b0;
        tick();
        check("hold.done", done0, 1'b1);
        check("hold.s",    s0, 16'h0123);
        check("hold.cout", cout0, 1'b0);
        tick();
        check("hold.idle", busy0, 1'b0);

        // Back-to-back: new start in the done cycle.
        x = 16'h0010; y = 16'h0020; as = 1'b0; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        wait_done0(lat, bc);
        check("b2b.lat1", lat, 4);
        check("b2b.s1",   s0, 16'h0030);
        x = 16'h1000; y = 16'h0001; as = 1'b1; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        check("b2b.busy", busy0, 1'b1);
        wait_done0(lat, bc);
        check("b2b.gap",  lat + 1, 5);
        check("b2b.s2",   s0, 16'h0FFF);
        check("b2b.cout", cout0, 1'b1);
        check("b2b.ovf",  ovf0, 1'b0);

        // Reset on the second RUN edge aborts the op without a done pulse.
        x = 16'h00FF; y = 16'h0001; as = 1'b0; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mrst.busy",  busy0, 1'b0);
        check("mrst.done",  done0, 1'b0);
        check("mrst.s",     s0, 16'h0000);
        check("mrst.flags", {cout0, ovf0, zero0}, 3'b000);
        dseen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done0) dseen++;
        end
        check("mrst.nodone", dseen, 0);
        op0("post",  16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0);

        // Random sweep on the CHUNK=16 and CHUNK=1 instances.
        for (int k = 0; k < 200; k++) begin
            x  = 16'($urandom);
            y  = 16'($urandom);
            as = 1'($urandom);
            if (k < 4) begin
                x = (k[0]) ? 16'h8000 : 16'h7FFF;
                y = (k[1]) ? 16'h0001 : 16'h8000;
            end
            exp = model(x, y, as);
            start1 = 1'b1; start2 = 1'b1;
            tick();
            start1 = 1'b0; start2 = 1'b0;
            lat1 = -1; lat2 = -1;
            for (int n = 1; n <= 40 && (lat1 < 0 || lat2 < 0); n++) begin
                tick();
                if (done1 && lat1 < 0) begin
                    lat1 = n;
                    check("c16.s",    s1, exp[15:0]);
                    check("c16.cout", cout1, exp[16]);
                    check("c16.ovf",  ovf1, exp[17]);
                    check("c16.zero", zero1, exp[18]);
                end
                if (done2 && lat2 < 0) begin
                    lat2 = n;
                    check("c1.s",    s2, exp[15:0]);
                    check("c1.cout", cout2, exp[16]);
                    check("c1.ovf",  ovf2, exp[17]);
                    check("c1.zero", zero2, exp[18]);
                end
            end
            check("c16.lat", lat1, 1);
            check("c1.lat",  lat2, 16);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/seq_addsub.md
Name: seq_addsub

Overview:
- Parametrised, multi-cycle two's-complement adder/subtractor; next generation of the team's 4-bit ripple add/sub unit.
- Processes a WIDTH-bit operation CHUNK bits per clock, LSB chunk first, with the carry held in a register between chunks.
- Adds a start/busy/done handshake, registered results and status flags (carry, signed overflow, zero).
- Used wherever a wide add/sub is needed and area matters more than latency.

Parameters:
- WIDTH, 16, operand and result width in bits; must be an integer multiple of CHUNK.
- CHUNK, 4, bits processed per clock cycle; 1 <= CHUNK <= WIDTH.
- N (localparam), WIDTH/CHUNK, number of RUN cycles per operation.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request a new operation; sampled only when busy=0.
- x  input  WIDTH  operand A.
- y  input  WIDTH  operand B.
- as  input  1  mode: 0 = x+y, 1 = x-y, computed as x + ~y + 1.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when the result and flags are updated.
- s  output  WIDTH  result; holds its value between operations.
- cout  output  1  carry out of the MSB. In subtract mode, 1 means no borrow (x >= y unsigned).
- ovf  output  1  signed overflow: carry into the MSB XOR carry out of the MSB.
- zero  output  1  high when s == 0.

Behaviour:
- Reset: when rst_n=0 at an edge, the following are cleared:
  - state = IDLE; busy = 0; done = 0.
  - s = 0; cout = 0; ovf = 0; zero = 0.
  - Internal operand, accumulator, carry and index registers = 0.
  - Reset overrides everything, including a start on the same edge.
- States: IDLE and RUN.
- IDLE:
  - On an edge with start=1, capture x into opa, (y XOR {WIDTH{as}}) into opb, carry = as, idx = 0.
  - Go to RUN; busy = 1.
  - start=0: remain in IDLE.
- RUN, one chunk per edge:
  - {c, sum} = opa[idx chunk] + opb[idx chunk] + carry.
  - Write sum into the accumulator slice idx; carry <= c; idx <= idx+1.
  - Record the carry into bit WIDTH-1 on the MSB chunk (needed for ovf).
- Completion, on the edge that processes chunk N-1 (the Nth RUN edge):
  - s <= full accumulator; cout <= final carry; ovf <= carry-into-MSB XOR carry-out; zero <= (result == 0).
  - done <= 1 for exactly one cycle; busy <= 0; return to IDLE.
- Latency: done is high during the cycle following the Nth edge after the edge that sampled start. For N=1 this is the edge after the start edge.
- Outputs s, cout, ovf and zero change only at completion; no partial results are ever visible on s.
- start while busy=1 is ignored, not queued.
- Changes on x, y or as during RUN have no effect, because operands are captured at start.
- Back-to-back: start may be asserted in the cycle where done=1 (busy=0 there); that start is accepted on that edge. Throughput is one result per N+1 cycles.
- Wrap-around: results are modulo 2^WIDTH; the idx counter wraps only through the return to IDLE.
- Reset mid-operation: the operation is aborted and done is not pulsed.

Test Plan (WIDTH=16, CHUNK=4 unless stated):
- add 0x0002+0x0004, start 1 cycle -> done exactly 4 edges later; s=0x0006, cout=0, ovf=0, zero=0; busy high for exactly 4 cycles.
- sub 0xFFFF-0xFFFC -> s=0x0003, cout=1; then sub 0x0003-0x0005 -> s=0xFFFE, cout=0, ovf=0; then sub 0x0005-0x0005 -> s=0x0000, zero=1, cout=1.
- add 0x7FFF+0x0001 -> s=0x8000, ovf=1, cout=0. add 0xFFFF+0x0001 -> s=0x0000, cout=1, zero=1, ovf=0. sub 0x8000-0x0001 -> s=0x7FFF, ovf=1, cout=1.
- Handshake:
  - Hold start high and toggle x, y, as during RUN -> only the first operation runs, and its result matches the captured operands.
  - Assert start in the done cycle with new operands -> second done occurs 5 cycles after the first.
- Reset: drop rst_n for 1 cycle at the 2nd RUN edge -> busy=0, s=0, flags=0, no done pulse; a subsequent op 0x1234+0x1111 -> s=0x2345.
- Parameter sweep: CHUNK=16 (N=1) and CHUNK=1 (N=16) with 200 random add/sub ops each -> all results and flags match the reference model; latency is N edges.
